spislave: RTL and testbench
===========================

Name: spislave

Overview:
- System-clock-domain SPI slave (mode 0, MSB-first) between the external ESP32 SPI pins and the spiregs command decoder.
- Oversamples SCLK/SSEL/MOSI with clk, assembles a command byte plus up to 8 payload bytes, and pulses spi_msg_end when SSEL deasserts.
- Optionally returns a 64-bit response on MISO after the command byte.

Parameters:
- SYNC_STAGES, 3, synchroniser depth for spi_sclk, spi_ssel_n and spi_mosi (minimum 2).

Ports:
- clk  input  1  system clock
- reset  input  1  async active-high reset
- spi_ssel_n  input  1  SPI chip select, active low, asynchronous
- spi_sclk  input  1  SPI clock, asynchronous, f(sclk) <= f(clk)/8
- spi_mosi  input  1  SPI data in
- spi_miso  output  1  SPI data out
- spi_msg_end  output  1  one-cycle pulse: message complete
- spi_cmd  output  8  first byte of current/last message
- spi_rxdata  output  64  payload bytes, newest byte in [63:56]
- spi_txdata  input  64  response data from decoder
- spi_txdata_valid  input  1  response present for current spi_cmd

Behaviour:
- Reset is asynchronous, active high. All registers clear: spi_cmd=8'h00, spi_rxdata=0, spi_msg_end=0, spi_miso=0, state=IDLE, synchronisers=idle levels (sclk=0, ssel_n=1).
- Synchroniser and edge detection:
  - All three pins pass through SYNC_STAGES flops.
  - Rising/falling SCLK and SSEL edges are detected from the last two synchronised samples.
- FSM states are IDLE, CMD, DATA.
  - IDLE: on synced ssel_n falling edge, go to CMD. Clear bit counter and shift register. Clear spi_rxdata to 0. spi_cmd keeps its old value.
  - CMD: on each SCLK rising edge, shift MOSI into an 8-bit shift register (MSB first). On the 8th bit, in the same cycle:
    - spi_cmd <= assembled byte.
    - Go to DATA.
  - The tx shifter loads one cycle later, from spi_txdata if spi_txdata_valid=1, else from 64'h0. This gives the decoder one clk to react to the new spi_cmd.
  - DATA: on each 8th SCLK rising edge, spi_rxdata <= {byte, spi_rxdata[63:8]}.
    - More than 8 payload bytes: oldest bytes drop out, so the last 8 bytes are retained.
    - Fewer than 8 bytes: unused low bytes stay 0.
- SSEL rising edge (synced) in any state other than IDLE:
  - Go to IDLE.
  - Pulse spi_msg_end for exactly one cycle, only if state was DATA (command byte complete).
  - Abort in CMD gives no pulse, and spi_cmd is unchanged.
  - A partial trailing data byte is discarded; spi_rxdata holds only complete bytes.
- spi_cmd and spi_rxdata stay stable from spi_msg_end until the next ssel_n falling edge.
- MISO:
  - Changes only on synced SCLK falling edges while in DATA.
  - Tx order is byte 0 = spi_txdata[7:0] first, then [15:8], and so on; each byte MSB first.
  - After 64 bits, shifts 0.
  - MISO=0 in IDLE and CMD.
- Latency: spi_msg_end asserts SYNC_STAGES+1 clk cycles after the physical SSEL rising edge.
- Glitch rule: ssel_n falling while already in CMD/DATA is impossible, since the edge detector needs a preceding rise. A rise always ends the message first.
- Reset mid-message: returns to IDLE with no spi_msg_end. The next message needs a fresh ssel_n falling edge.

Decomposition:
- No shared package is needed; state encoding stays as localparams inside the module.
- One natural sub-module, spi_sync: an N-stage synchroniser with async reset and a reset-value parameter, instantiated three times.

Test Plan:
- Send cmd 8'h10 plus 8 bytes 01..08 (1st..8th), raise SSEL -> one spi_msg_end pulse; spi_cmd=8'h10; spi_rxdata=64'h0807060504030201.
- Send cmd 8'h11 plus bytes AA, 55 -> spi_rxdata=64'h55AA000000000000; spi_msg_end pulses once.
- Send cmd 8'h12 plus 10 bytes 01..0A -> spi_rxdata=64'h0A09080706050403.
- Raise SSEL after 5 bits of the command byte -> no spi_msg_end; spi_cmd retains the previous value 8'h12.
- Drive spi_txdata=64'h1122334455667788 with valid=1, send cmd plus 8 dummy bytes -> MISO bytes 88,77,66,55,44,33,22,11, sampled on SCLK rising edges.
- Assert reset mid-payload, then send full message 8'h40, 01 -> first message produces no pulse; second gives spi_cmd=8'h40, spi_rxdata[63:56]=8'h01.

Source files
------------

// File: rtl/spi_sync.sv
// N-stage flop synchroniser for one asynchronous input pin.
// The reset value lets each pin start at its idle level.
module spi_sync #(
    parameter int   STAGES    = 3,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the pin level through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/spislave.sv
// Oversampled SPI mode-0 slave: command byte, up to 8 retained payload bytes,
// and a 64-bit response shifted out on MISO after the command byte.
module spislave #(
    parameter int SYNC_STAGES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_ssel_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_msg_end,
    output logic [7:0]  spi_cmd,
    output logic [63:0] spi_rxdata,
    input  logic [63:0] spi_txdata,
    input  logic        spi_txdata_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Byte 0 of the response goes first, so it is moved to the top of the shifter.
    function automatic logic [63:0] byte_reverse(input logic [63:0] d);
        logic [63:0] r;
        r = 64'h0;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return r;
    endfunction

    logic        sclk_s;
    logic        ssel_n_s;
    logic        mosi_s;
    logic        sclk_prev_r;
    logic        ssel_n_prev_r;
    logic        sclk_rise_s;
    logic        sclk_fall_s;
    logic        ssel_rise_s;
    logic        ssel_fall_s;
    logic [7:0]  next_byte_s;
    logic        bit_last_s;
    state_t      state_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic [63:0] tx_shift_r;
    logic        tx_load_r;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(spi_sclk), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ssel (
        .clk(clk), .reset(reset), .d(spi_ssel_n), .q(ssel_n_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(spi_mosi), .q(mosi_s)
    );

    assign sclk_rise_s = sclk_s & ~sclk_prev_r;
    assign sclk_fall_s = ~sclk_s & sclk_prev_r;
    assign ssel_rise_s = ssel_n_s & ~ssel_n_prev_r;
    assign ssel_fall_s = ~ssel_n_s & ssel_n_prev_r;
    assign next_byte_s = {shift_r[6:0], mosi_s};
    assign bit_last_s  = (bit_cnt_r == 3'd7);

    // Message FSM with edge history, byte assembly and MISO shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_prev_r   <= 1'b0;
            ssel_n_prev_r <= 1'b1;
            state_r       <= IDLE;
            bit_cnt_r     <= 3'd0;
            shift_r       <= 8'h00;
            tx_shift_r    <= 64'h0;
            tx_load_r     <= 1'b0;
            spi_cmd       <= 8'h00;
            spi_rxdata    <= 64'h0;
            spi_msg_end   <= 1'b0;
            spi_miso      <= 1'b0;
        end else begin
            sclk_prev_r   <= sclk_s;
            ssel_n_prev_r <= ssel_n_s;
            spi_msg_end   <= 1'b0;
            tx_load_r     <= 1'b0;
            // Loaded a cycle after spi_cmd updates so the decoder can respond.
            if (tx_load_r) begin
                tx_shift_r <= spi_txdata_valid ? byte_reverse(spi_txdata) : 64'h0;
            end
            case (state_r)
                IDLE: begin
                    spi_miso <= 1'b0;
                    if (ssel_fall_s) begin
                        state_r    <= CMD;
                        bit_cnt_r  <= 3'd0;
                        shift_r    <= 8'h00;
                        spi_rxdata <= 64'h0;
                    end
                end
                CMD: begin
                    spi_miso <= 1'b0;
                    if (ssel_rise_s) begin
                        state_r <= IDLE;
                    end else if (sclk_rise_s) begin
                        shift_r   <= next_byte_s;
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_last_s) begin
                            spi_cmd   <= next_byte_s;
                            state_r   <= DATA;
                            tx_load_r <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (ssel_rise_s) begin
                        state_r     <= IDLE;
                        spi_msg_end <= 1'b1;
                        spi_miso    <= 1'b0;
                    end else begin
                        if (sclk_rise_s) begin
                            shift_r   <= next_byte_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_last_s) begin
                                spi_rxdata <= {next_byte_s, spi_rxdata[63:8]};
                            end
                        end
                        if (sclk_fall_s) begin
                            spi_miso   <= tx_shift_r[63];
                            tx_shift_r <= {tx_shift_r[62:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    spi_miso <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spislave.sv
// Randomised and directed bench for spislave against a message-level model
// (bytes in, expected command/payload/MISO bit stream out).
module tb_spislave;

    localparam int SYNC = 3;
    localparam int H    = 6;

    logic        clk = 1'b0;
    logic        reset, ssel_n, sclk, mosi;
    logic        miso, msg_end;
    logic [7:0]  cmd;
    logic [63:0] rxdata, txdata;
    logic        txv;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          end_cyc = -1;
    int          pulses = 0;
    bit          hold = 1'b0;
    logic [7:0]  exp_cmd = 8'h00;
    logic [63:0] exp_rx = 64'h0;
    logic [63:0] miso_cap;

    spislave #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .spi_ssel_n(ssel_n), .spi_sclk(sclk),
        .spi_mosi(mosi), .spi_miso(miso), .spi_msg_end(msg_end),
        .spi_cmd(cmd), .spi_rxdata(rxdata), .spi_txdata(txdata),
        .spi_txdata_valid(txv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare of the pulse timing and the held message outputs.
    always @(negedge clk) begin
        checks++;
        if (msg_end !== (cyc == end_cyc)) begin
            errors++;
            $display("FAIL msg_end cyc=%0d got=%b want=%b", cyc, msg_end, (cyc == end_cyc));
        end
        if (msg_end === 1'b1) pulses++;
        if (cyc == end_cyc || hold) begin
            checks++;
            if (cmd !== exp_cmd || rxdata !== exp_rx || (hold && miso !== 1'b0)) begin
                errors++;
                $display("FAIL held_outputs cyc=%0d got cmd=%h rx=%h miso=%b want cmd=%h rx=%h miso=0",
                         cyc, cmd, rxdata, miso, exp_cmd, exp_rx);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Response bit i after the command byte: bytes LSB-byte first, each MSB first.
    function automatic logic exp_miso(input int i);
        if (!txv || i >= 64) return 1'b0;
        return txdata[8*(i/8) + 7 - (i%8)];
    endfunction

    task automatic do_reset();
        reset  = 1'b1;
        ssel_n = 1'b1;
        sclk   = 1'b0;
        mosi   = 1'b0;
        tick(3);
        reset   = 1'b0;
        exp_cmd = 8'h00;
        exp_rx  = 64'h0;
        end_cyc = -1;
        tick(10);
        hold = 1'b1;
        tick(4);
    endtask

    task automatic send_msg(input logic [7:0] b[$], input int nbits, input int rst_at);
        int         complete;
        logic [7:0] cur;
        logic       want;
        hold   = 1'b0;
        ssel_n = 1'b0;
        tick(H);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                do_reset();
                return;
            end
            cur  = b[i/8];
            mosi = cur[7 - (i%8)];
            tick(H);
            want = (i < 8) ? 1'b0 : exp_miso(i - 8);
            checks++;
            if (miso !== want) begin
                errors++;
                $display("FAIL miso bit=%0d got=%b want=%b", i, miso, want);
            end
            if (i >= 8) miso_cap = {miso_cap[62:0], miso};
            sclk = 1'b1;
            tick(H);
            sclk = 1'b0;
        end
        tick(H);
        complete = nbits / 8;
        exp_rx = 64'h0;
        if (complete >= 1) begin
            exp_cmd = b[0];
            for (int k = 0; k < complete - 1 && k < 8; k++) begin
                exp_rx[56 - 8*k +: 8] = b[complete - 1 - k];
            end
        end
        ssel_n = 1'b1;
        if (complete >= 1) end_cyc = cyc + SYNC + 1;
        tick(SYNC + 4);
        hold = 1'b1;
        tick(6);
    endtask

    initial begin
        logic [7:0] q[$];
        int         p0, n, nbits;
        reset  = 1'b1;
        ssel_n = 1'b1;
        sclk   = 1'b0;
        mosi   = 1'b0;
        txdata = 64'h0;
        txv    = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);
        hold = 1'b1;
        tick(4);
        chk("reset_cmd", {56'h0, cmd}, 64'h0);
        chk("reset_rx", rxdata, 64'h0);
        chk("reset_miso_end", {62'h0, miso, msg_end}, 64'h0);

        q = {8'h10};
        for (int i = 1; i <= 8; i++) q.push_back(8'(i));
        p0 = pulses;
        send_msg(q, 72, -1);
        chk("m1_cmd", {56'h0, cmd}, 64'h10);
        chk("m1_rx", rxdata, 64'h0807060504030201);
        chk("m1_pulses", 64'(pulses - p0), 64'd1);

        q = {8'h11, 8'hAA, 8'h55};
        p0 = pulses;
        send_msg(q, 24, -1);
        chk("m2_rx", rxdata, 64'h55AA000000000000);
        chk("m2_pulses", 64'(pulses - p0), 64'd1);

        q = {8'h12};
        for (int i = 1; i <= 10; i++) q.push_back(8'(i));
        send_msg(q, 88, -1);
        chk("m3_rx", rxdata, 64'h0A09080706050403);

        q = {8'hF5};
        p0 = pulses;
        send_msg(q, 5, -1);
        chk("abort_cmd", {56'h0, cmd}, 64'h12);
        chk("abort_pulses", 64'(pulses - p0), 64'd0);

        txdata = 64'h1122334455667788;
        txv    = 1'b1;
        q = {8'h20};
        for (int i = 1; i <= 8; i++) q.push_back(8'($urandom));
        miso_cap = 64'h0;
        send_msg(q, 72, -1);
        chk("miso_bytes", miso_cap, 64'h8877665544332211);

        q = {8'h30, 8'hDE, 8'hAD, 8'hBE};
        p0 = pulses;
        send_msg(q, 32, 20);
        chk("rst_pulses", 64'(pulses - p0), 64'd0);
        q = {8'h40, 8'h01};
        send_msg(q, 16, -1);
        chk("after_rst_cmd", {56'h0, cmd}, 64'h40);
        chk("after_rst_rx_top", {56'h0, rxdata[63:56]}, 64'h01);
        chk("after_rst_pulses", 64'(pulses - p0), 64'd1);

        for (int m = 0; m < 20; m++) begin
            txdata = {$urandom, $urandom};
            txv    = 1'($urandom_range(0, 1));
            n      = $urandom_range(0, 10);
            q = {};
            for (int i = 0; i < n + 2; i++) q.push_back(8'($urandom));
            nbits = (n + 1) * 8;
            if ($urandom_range(0, 3) == 0) nbits += $urandom_range(1, 7);
            if ($urandom_range(0, 7) == 0) nbits = $urandom_range(1, 7);
            send_msg(q, nbits, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
